// File: rtl/pipe_trace_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_trace_if
// Brief   : Control, pipeline-sample and read-port bundle for pipe_trace_buf.
//           master = the debug host/bench; slave = the trace buffer.
// Revision: 1.0  initial release
// ============================================================================
interface pipe_trace_if #(
  parameter int NSTAGE = 5,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 64
);
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_DW = 17 + NSTAGE * (PC_W + 1);

  logic                   arm;
  logic                   oneshot;
  logic [c_AW-1:0]        post_len;
  logic [PC_W-1:0]        trig_pc;
  logic [NSTAGE*PC_W-1:0] stage_pc;
  logic [NSTAGE-1:0]      stage_vld;
  logic                   stall;
  logic                   rd_en;
  logic [c_AW-1:0]        rd_idx;
  logic [c_DW-1:0]        rd_data;
  logic                   rd_vld;
  logic                   rd_err;
  logic [1:0]             state;
  logic [c_AW:0]          count;
  logic                   trig_seen;

  modport master (
    output arm, oneshot, post_len, trig_pc, stage_pc, stage_vld, stall, rd_en, rd_idx,
    input  rd_data, rd_vld, rd_err, state, count, trig_seen
  );

  modport slave (
    input  arm, oneshot, post_len, trig_pc, stage_pc, stage_vld, stall, rd_en, rd_idx,
    output rd_data, rd_vld, rd_err, state, count, trig_seen
  );
endinterface
`default_nettype wire

// File: rtl/pipe_trace_buf.sv
`default_nettype none
// ============================================================================
// Module  : pipe_trace_buf
// Brief   : Per-cycle pipeline trace recorder. Captures {stamp, stall,
//           stage_vld, stage_pc} into a circular buffer, with a PC-match
//           trigger, programmable post-trigger length and one-shot mode.
//           Entries are drained through a registered indexed read port.
// Revision: 1.0  initial release
// ============================================================================
module pipe_trace_buf #(
  parameter int NSTAGE     = 5,
  parameter int PC_W       = 32,
  parameter int DEPTH      = 64,
  parameter int TRIG_STAGE = 0,
  parameter int SKIP_STALL = 0
) (
  input  logic        clk,
  input  logic        reset,
  pipe_trace_if.slave bus
);
  localparam int            c_AW   = $clog2(DEPTH);
  localparam int            c_DW   = 17 + NSTAGE * (PC_W + 1);
  localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0] c_LAST = (c_AW+1)'(DEPTH - 1);
  localparam bit            c_SKIP = (SKIP_STALL != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_AW:0]   r_count;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_post_left;
  logic [c_AW-1:0] r_post_len;
  logic [15:0]     r_stamp;
  logic            r_trig_seen;
  logic            r_oneshot;
  logic [PC_W-1:0] r_trig_pc;

  logic [c_DW-1:0] r_mem [DEPTH];
  logic [c_DW-1:0] r_rd_data;
  logic            r_rd_vld;
  logic            r_rd_err;

  logic            w_cap;
  logic            w_trig;
  logic [PC_W-1:0] w_trig_stage_pc;
  logic [c_DW-1:0] w_wr_data;
  logic [c_AW-1:0] w_rd_addr;
  logic            w_rd_oob;

  // arm owns its cycle: nothing is written or trigger-checked while restarting
  assign w_cap = !bus.arm && (r_state == S_ARMED || r_state == S_POST) &&
                 !(c_SKIP && bus.stall);
  assign w_trig_stage_pc = bus.stage_pc[TRIG_STAGE*PC_W +: PC_W];
  assign w_trig = w_cap && (r_state == S_ARMED) && bus.stage_vld[TRIG_STAGE] &&
                  (w_trig_stage_pc == r_trig_pc);
  assign w_wr_data = {r_stamp, bus.stall, bus.stage_vld, bus.stage_pc};
  // oldest entry sits count slots behind the write pointer (count==DEPTH -> at wr_ptr)
  assign w_rd_addr = r_wr_ptr - r_count[c_AW-1:0] + bus.rd_idx;
  assign w_rd_oob  = {1'b0, bus.rd_idx} >= r_count;

  // next-state decode for the capture controller
  always_comb begin
    w_state_nxt = r_state;
    if (bus.arm) begin
      w_state_nxt = S_ARMED;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (w_trig) begin
            w_state_nxt = (r_post_len == '0) ? S_DONE : S_POST;
          end else if (w_cap && r_oneshot && (r_count == c_LAST)) begin
            w_state_nxt = S_DONE;
          end
        end
        S_POST: begin
          if (w_cap && (r_post_left == c_AW'(1))) begin
            w_state_nxt = S_DONE;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // capture bookkeeping: stamp, pointer, count, trigger and post-trigger countdown
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stamp     <= '0;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_trig_seen <= 1'b0;
      r_oneshot   <= 1'b0;
      r_post_len  <= '0;
      r_post_left <= '0;
      r_trig_pc   <= '0;
    end else begin
      r_stamp <= r_stamp + 16'd1;
      if (bus.arm) begin
        r_count     <= '0;
        r_wr_ptr    <= '0;
        r_trig_seen <= 1'b0;
        r_oneshot   <= bus.oneshot;
        r_post_len  <= bus.post_len;
        r_trig_pc   <= bus.trig_pc;
      end else if (w_cap) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_count != c_FULL) begin
          r_count <= r_count + 1'b1;
        end
        if (w_trig) begin
          r_trig_seen <= 1'b1;
          r_post_left <= r_post_len;
        end else if (r_state == S_POST) begin
          r_post_left <= r_post_left - 1'b1;
        end
      end
    end
  end

  // buffer write port; contents are left alone by reset
  always_ff @(posedge clk) begin
    if (reset && w_cap) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  // registered read port; sees pre-write contents when a capture shares the edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_vld  <= 1'b0;
      r_rd_err  <= 1'b0;
      r_rd_data <= '0;
    end else if (bus.rd_en) begin
      r_rd_vld  <= 1'b1;
      r_rd_err  <= w_rd_oob;
      r_rd_data <= w_rd_oob ? '0 : r_mem[w_rd_addr];
    end else begin
      r_rd_vld <= 1'b0;
      r_rd_err <= 1'b0;
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.rd_vld    = r_rd_vld;
  assign bus.rd_err    = r_rd_err;
  assign bus.state     = r_state;
  assign bus.count     = r_count;
  assign bus.trig_seen = r_trig_seen;
endmodule
`default_nettype wire

// File: tb/tb_pipe_trace_buf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_pipe_trace_buf
// Brief   : Directed bench for pipe_trace_buf. Instance A (SKIP_STALL=0) is
//           tracked cycle by cycle against a queue-based reference; instance
//           B (SKIP_STALL=1) covers stall skipping.
// Revision: 1.0  initial release
// ============================================================================
module tb_pipe_trace_buf;
  localparam int NS = 5;
  localparam int PW = 32;
  localparam int DP = 64;
  localparam int AW = 6;
  localparam int DW = 17 + NS * (PW + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_trace_if #(.NSTAGE(NS), .PC_W(PW), .DEPTH(DP)) ia ();
  pipe_trace_if #(.NSTAGE(NS), .PC_W(PW), .DEPTH(DP)) ib ();

  pipe_trace_buf #(.NSTAGE(NS), .PC_W(PW), .DEPTH(DP), .TRIG_STAGE(0), .SKIP_STALL(0))
    u_a (.clk(clk), .reset(reset), .bus(ia));
  pipe_trace_buf #(.NSTAGE(NS), .PC_W(PW), .DEPTH(DP), .TRIG_STAGE(0), .SKIP_STALL(1))
    u_b (.clk(clk), .reset(reset), .bus(ib));

  int n_vec = 0;
  int n_err = 0;

  // reference for instance A
  int              ms;
  logic [DW-1:0]   mq[$];
  logic [DW:0]     rdq[$];
  logic            mtrig;
  int              mpost;
  logic            mone;
  logic [AW-1:0]   mplen;
  logic [PW-1:0]   mtpc;
  logic [15:0]     mstamp;
  logic [DW-1:0]   last_rd;
  logic [15:0]     t_arm;

  // expectations for instance B
  logic [DW-1:0]   qb[$];
  logic [DW:0]     rbq[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS*PW-1:0] mkpc(input logic [PW-1:0] pc0);
    return {pc0 - 32'd16, pc0 - 32'd12, pc0 - 32'd8, pc0 - 32'd4, pc0};
  endfunction

  task automatic drv(input logic [PW-1:0] pc0, input logic [NS-1:0] v, input logic st);
    ia.stage_pc  = mkpc(pc0);
    ia.stage_vld = v;
    ia.stall     = st;
  endtask

  // one clock edge: advance the reference with the inputs present at the edge,
  // then check A's outputs 1ns after the edge
  task automatic tick();
    logic          was_rst;
    logic          rd_q;
    logic          full;
    logic [DW:0]   exp;
    was_rst = !reset;
    rd_q    = reset && ia.rd_en;
    if (was_rst) begin
      ms = 0; mq.delete(); rdq.delete(); mtrig = 1'b0; mstamp = '0; mpost = 0;
    end else begin
      if (ia.rd_en) begin
        if (int'(ia.rd_idx) >= mq.size()) rdq.push_back({1'b1, {DW{1'b0}}});
        else                              rdq.push_back({1'b0, mq[ia.rd_idx]});
      end
      if (ia.arm) begin
        ms = 1; mq.delete(); mtrig = 1'b0;
        mone = ia.oneshot; mplen = ia.post_len; mtpc = ia.trig_pc;
      end else if (ms == 1 || ms == 2) begin
        mq.push_back({mstamp, ia.stall, ia.stage_vld, ia.stage_pc});
        full = (mq.size() == DP);
        if (mq.size() > DP) void'(mq.pop_front());
        if (ms == 1) begin
          if (ia.stage_vld[0] && ia.stage_pc[PW-1:0] == mtpc) begin
            mtrig = 1'b1;
            if (mplen == '0) ms = 3;
            else begin ms = 2; mpost = int'(mplen); end
          end else if (mone && full) begin
            ms = 3;
          end
        end else begin
          mpost--;
          if (mpost == 0) ms = 3;
        end
      end
      mstamp = mstamp + 16'd1;
    end
    @(posedge clk);
    #1;
    if (rd_q) begin
      exp = rdq.pop_front();
      chk("rd_vld", ia.rd_vld, 1);
      chk("rd_err", ia.rd_err, exp[DW]);
      chk("rd_data", ia.rd_data, exp[DW-1:0]);
      last_rd = exp[DW-1:0];
    end else begin
      if (was_rst) last_rd = '0;
      chk("rd_vld_idle", ia.rd_vld, 0);
      chk("rd_err_idle", ia.rd_err, 0);
      chk("rd_data_hold", ia.rd_data, last_rd);
    end
    chk("state", ia.state, ms);
    chk("count", ia.count, mq.size());
    chk("trig_seen", ia.trig_seen, mtrig);
  endtask

  task automatic rd(input int idx);
    ia.rd_en  = 1'b1;
    ia.rd_idx = AW'(idx);
    tick();
    ia.rd_en  = 1'b0;
  endtask

  task automatic arm_a(input logic os, input logic [AW-1:0] pl, input logic [PW-1:0] tp);
    ia.oneshot  = os;
    ia.post_len = pl;
    ia.trig_pc  = tp;
    ia.arm      = 1'b1;
    tick();
    ia.arm      = 1'b0;
  endtask

  initial begin
    logic [DW:0] e;
    ia.arm = 0; ia.oneshot = 0; ia.post_len = '0; ia.trig_pc = '0; ia.stage_pc = '0;
    ia.stage_vld = '0; ia.stall = 0; ia.rd_en = 0; ia.rd_idx = '0;
    ib.arm = 0; ib.oneshot = 0; ib.post_len = '0; ib.trig_pc = '0; ib.stage_pc = '0;
    ib.stage_vld = '0; ib.stall = 0; ib.rd_en = 0; ib.rd_idx = '0;
    ms = 0; mtrig = 0; mpost = 0; mone = 0; mplen = '0; mtpc = '0; mstamp = '0; last_rd = '0;

    // reset state
    tick(); tick();
    reset = 1'b1;
    tick();

    // wrap without trigger: 100 captures into 64 entries
    t_arm = mstamp;
    arm_a(1'b0, 6'd3, 32'hFFFF_FFF0);
    for (int i = 0; i < 100; i++) begin
      drv(32'h1000 + 32'(4 * i), 5'h1F, (i % 7) == 3);
      tick();
    end
    chk("t2_count", ia.count, 64);
    chk("t2_state", ia.state, 1);
    rd(0);
    chk("t2_oldest_stamp", ia.rd_data[DW-1 -: 16], t_arm + 16'd37);
    rd(63);
    rd(17);
    tick();

    // trigger with post_len=3; valid-less PC match must be ignored
    arm_a(1'b0, 6'd3, 32'h0000_3000);
    for (int i = 0; i < 5; i++) begin
      drv(32'h2000 + 32'(4 * i), 5'h1F, 1'b0);
      tick();
    end
    drv(32'h3000, 5'h1E, 1'b0); tick();
    chk("t3_novld_state", ia.state, 1);
    drv(32'h3000, 5'h1F, 1'b0); tick();
    chk("t3_trig_state", ia.state, 2);
    for (int i = 0; i < 3; i++) begin
      drv(32'h3000, 5'h1F, i == 1);
      tick();
      chk("t3_post_state", ia.state, (i == 2) ? 3 : 2);
    end
    chk("t3_count", ia.count, 10);
    chk("t3_trig_seen", ia.trig_seen, 1);
    rd(6);
    chk("t3_trig_pc", ia.rd_data[PW-1:0], 32'h3000);
    rd(10);
    chk("t3_oob_err", ia.rd_err, 1);
    chk("t3_oob_data", ia.rd_data, 0);
    drv(32'h4000, 5'h1F, 1'b0); tick(); tick();

    // reset mid-POST
    arm_a(1'b0, 6'd10, 32'h0000_3000);
    drv(32'h5000, 5'h1F, 1'b0); tick(); tick();
    drv(32'h3000, 5'h1F, 1'b0); tick();
    drv(32'h5100, 5'h1F, 1'b0); tick(); tick();
    chk("t1_pre_state", ia.state, 2);
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("t1_state", ia.state, 0);
    chk("t1_count", ia.count, 0);
    chk("t1_trig_seen", ia.trig_seen, 0);
    chk("t1_rd_vld", ia.rd_vld, 0);
    tick();

    // post_len=0: match goes straight to DONE
    arm_a(1'b0, 6'd0, 32'h0000_3000);
    drv(32'h6000, 5'h1F, 1'b0); tick(); tick();
    drv(32'h3000, 5'h1F, 1'b0); tick();
    chk("t4a_state", ia.state, 3);
    chk("t4a_count", ia.count, 3);
    tick();

    // one-shot without trigger stops at a full buffer
    arm_a(1'b1, 6'd5, 32'hFFFF_FFF0);
    for (int i = 0; i < 63; i++) begin
      drv(32'h7000 + 32'(4 * i), 5'h1F, 1'b0);
      tick();
    end
    chk("t4b_pre_state", ia.state, 1);
    tick();
    chk("t4b_state", ia.state, 3);
    chk("t4b_count", ia.count, 64);
    chk("t4b_trig_seen", ia.trig_seen, 0);
    tick(); tick();
    rd(0); rd(63);

    // arm coincident with a match: restart wins, no trigger
    arm_a(1'b0, 6'd2, 32'h0000_3000);
    drv(32'h8000, 5'h1F, 1'b0); tick(); tick();
    drv(32'h3000, 5'h1F, 1'b0);
    arm_a(1'b0, 6'd2, 32'h0000_3000);
    chk("t6_count", ia.count, 0);
    chk("t6_trig_seen", ia.trig_seen, 0);
    chk("t6_state", ia.state, 1);
    drv(32'h8100, 5'h1F, 1'b0); tick();
    chk("t6_count1", ia.count, 1);

    // SKIP_STALL instance: stalled cycles in POST are neither captured nor counted
    ib.trig_pc = 32'h0000_3000; ib.post_len = 6'd5; ib.oneshot = 1'b0;
    ib.arm = 1'b1; tick(); ib.arm = 1'b0;
    ib.stage_pc = mkpc(32'h9000); ib.stage_vld = 5'h1F; ib.stall = 1'b0;
    qb.push_back({mstamp, ib.stall, ib.stage_vld, ib.stage_pc});
    tick();
    ib.stage_pc = mkpc(32'h3000);
    qb.push_back({mstamp, ib.stall, ib.stage_vld, ib.stage_pc});
    tick();
    chk("t5_trig_state", ib.state, 2);
    for (int i = 0; i < 10; i++) begin
      ib.stall    = ((i % 2) == 0);
      ib.stage_pc = mkpc(32'hA000 + 32'(4 * i));
      if (!ib.stall) qb.push_back({mstamp, ib.stall, ib.stage_vld, ib.stage_pc});
      tick();
      chk("t5_post_state", ib.state, (i == 9) ? 3 : 2);
    end
    chk("t5_count", ib.count, 7);
    chk("t5_trig_seen", ib.trig_seen, 1);
    for (int i = 0; i < 8; i++) begin
      ib.rd_en  = 1'b1;
      ib.rd_idx = AW'(i);
      if (i < qb.size()) rbq.push_back({1'b0, qb[i]});
      else               rbq.push_back({1'b1, {DW{1'b0}}});
      tick();
      e = rbq.pop_front();
      chk("t5_rd_vld", ib.rd_vld, 1);
      chk("t5_rd_err", ib.rd_err, e[DW]);
      chk("t5_rd_data", ib.rd_data, e[DW-1:0]);
    end
    ib.rd_en = 1'b0;
    tick();
    chk("t5_rd_vld_off", ib.rd_vld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
